// File: rtl/booth_pkg.sv
// booth_pkg: shared encodings for the radix-2 Booth multiplier control path.
//   ctl_code_t : A/Q register control codes (Load/Reset/Shift/Hold)
//   M_LD/M_HD  : M register load/hold
//   ADD_OP/SUB_OP : add/sub unit operation select
//   state_t    : sequencer states
package booth_pkg;

    typedef enum logic [1:0] {
        CTL_LOAD  = 2'b00,
        CTL_RESET = 2'b01,
        CTL_SHIFT = 2'b10,
        CTL_HOLD  = 2'b11
    } ctl_code_t;

    localparam logic M_LD   = 1'b1;
    localparam logic M_HD   = 1'b0;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/booth_iter_counter.sv
// booth_iter_counter: remaining-iteration counter for the Booth sequencer.
//   clock, reset : clock and synchronous active-high clear
//   load         : load WIDTH (start of a multiply)
//   dec          : decrement by one (one iteration retired)
//   cnt          : current remaining iteration count
//   last         : high when cnt == 1 (the SHIFT in progress is the final one)
module booth_iter_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(WIDTH);
        end else if (dec) begin
            // Only decremented from SHIFT, where the count is at least 1.
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/booth_sequencer.sv
// booth_sequencer: multi-cycle control FSM for a radix-2 Booth multiplier
// datapath (A, Q, M registers, Q-1 bit, add/sub unit).
//   clock     : system clock, rising edge
//   reset     : synchronous active-high, forces IDLE and clears op/iter
//   start     : level request, launches a multiply when seen in IDLE
//   abort     : synchronous cancel back to IDLE without done
//   Q_in      : {Q[0], Q-1} from the datapath, sampled in EVAL only
//   Q_sig     : Q register control (Load/Reset/Shift/Hold)
//   A_sig     : A register control (same encoding)
//   M_sig     : M register control (LD=1, HD=0)
//   adder_sig : add/sub select (Add=0, Sub=1)
//   busy      : high in LOAD/EVAL/ADD/SHIFT
//   done_sig  : high while in DONE
//   iter      : remaining iterations
//
// Handshake: a request is accepted on the rising edge where start=1 and the
// FSM is in IDLE. done_sig then rises once the product is complete and stays
// high until the first edge with start=0, so a start held through completion
// cannot retrigger. start is ignored while busy; abort (any state) beats start.
//
// All outputs are decoded from registered state and the latched op bit only.
module booth_sequencer
    import booth_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       Q_in,
    output logic [1:0]       Q_sig,
    output logic [1:0]       A_sig,
    output logic             M_sig,
    output logic             adder_sig,
    output logic             busy,
    output logic             done_sig,
    output logic [CNT_W-1:0] iter
);

    state_t state_q;
    state_t state_d;
    logic   op_q;
    logic   op_d;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_last;

    booth_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .cnt   (iter),
        .last  (cnt_last)
    );

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_load = 1'b1;
                state_d  = ST_EVAL;
            end
            ST_EVAL: begin
                case (Q_in)
                    2'b01: begin
                        op_d    = ADD_OP;
                        state_d = ST_ADD;
                    end
                    2'b10: begin
                        op_d    = SUB_OP;
                        state_d = ST_ADD;
                    end
                    default: state_d = ST_SHIFT;
                endcase
            end
            ST_ADD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_dec = 1'b1;
                state_d = cnt_last ? ST_DONE : ST_EVAL;
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a start seen in IDLE.
        if (abort) begin
            state_d  = ST_IDLE;
            op_d     = op_q;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= ADD_OP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Moore output decode
    ctl_code_t q_ctl;
    ctl_code_t a_ctl;

    always_comb begin
        q_ctl    = CTL_HOLD;
        a_ctl    = CTL_HOLD;
        M_sig    = M_HD;
        busy     = 1'b0;
        done_sig = 1'b0;
        case (state_q)
            ST_LOAD: begin
                q_ctl = CTL_LOAD;
                a_ctl = CTL_RESET;
                M_sig = M_LD;
                busy  = 1'b1;
            end
            ST_EVAL: begin
                busy = 1'b1;
            end
            ST_ADD: begin
                a_ctl = CTL_LOAD;
                busy  = 1'b1;
            end
            ST_SHIFT: begin
                q_ctl = CTL_SHIFT;
                a_ctl = CTL_SHIFT;
                busy  = 1'b1;
            end
            ST_DONE: begin
                done_sig = 1'b1;
            end
            default: ;
        endcase
    end

    assign Q_sig     = q_ctl;
    assign A_sig     = a_ctl;
    // Outside ADD the adder select is a don't-care, so it simply tracks op.
    assign adder_sig = op_q;

    // The iteration counter must never underflow.
    a_shift_iter_nonzero: assert property (
        @(posedge clock) disable iff (reset) (state_q == ST_SHIFT) |-> (iter != '0)
    );

endmodule

// File: doc/booth_sequencer.md
Name: booth_sequencer

Overview:
Multi-cycle sequencer for the radix-2 Booth multiplier datapath (A, Q, M registers, Q-1 bit, add/sub unit).
- Accepts a start request and steps the datapath through load, evaluate, add/subtract and arithmetic shift for WIDTH iterations.
- Reports completion with a done/start handshake and supports synchronous abort.
- Sits between the top-level operand interface and the datapath; it replaces hand-driven control codes.

Parameters:
WIDTH, 4, operand width in bits; iteration count; legal range 1..32
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override)

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high; forces IDLE
start  in  1  level request; a multiply is launched on an edge where start=1 in IDLE
abort  in  1  synchronous cancel; returns to IDLE, no done
Q_in   in  2  {Q[0], Q-1} from datapath; sampled only in EVAL
Q_sig  out 2  Q register control: Load=00, Reset=01, Shift=10, Hold=11
A_sig  out 2  A register control, same encoding
M_sig  out 1  M register control: LD=1, HD=0
adder_sig out 1 adder op: Add=0, Sub=1
busy   out 1  high in every state except IDLE and DONE
done_sig out 1 high while in DONE
iter   out CNT_W  remaining iterations (debug/observability)

Behaviour:
- Moore outputs decoded from the registered state plus the latched op bit; no combinational path from any input to any output.
- Reset and IDLE outputs: Q_sig=Hold, A_sig=Hold, M_sig=HD, adder_sig=Add, busy=0, done_sig=0, iter=0.
- IDLE: if start=1, go to LOAD; otherwise stay.
- LOAD (1 cycle): Q_sig=Load, M_sig=LD, A_sig=Reset; iter<=WIDTH; next state is EVAL. The datapath clears Q-1 on Q Load.
- EVAL (1 cycle): all registers Hold.
  - Q_in=01: op<=Add, next ADD.
  - Q_in=10: op<=Sub, next ADD.
  - Q_in=00 or 11: next SHIFT.
- ADD (1 cycle): A_sig=Load, adder_sig=op, Q_sig=Hold; next SHIFT.
- SHIFT (1 cycle): A_sig=Shift, Q_sig=Shift; iter<=iter-1. If iter==1, next DONE; otherwise next EVAL.
- DONE: done_sig=1, all registers Hold. Stay while start=1; go to IDLE on the first edge with start=0. This prevents retrigger from a held start.
- adder_sig outside ADD: drives the latched op. Value is don't-care to the datapath, but must be deterministic and equal Add after reset.
- Latency: LOAD entered on the edge after start is sampled. Cycles from LOAD entry to DONE entry = 1 + sum over iterations of (2 + isAdd).
  - WIDTH=4, no adds: DONE at cycle 9.
  - WIDTH=4, all adds: DONE at cycle 13.
- start while busy: ignored.
- start in DONE: holds DONE only.
- Priority on any edge: reset > abort > normal transition.
- abort in any non-IDLE state, DONE included: next state IDLE; outputs Hold on the following cycle; done_sig never asserts for that operation.
- reset mid-operation: identical to abort, and additionally clears op and iter.
- iter never wraps. Decrement happens only in SHIFT, where iter>=1 by construction. An assertion must flag SHIFT with iter==0.
- WIDTH=1: exactly one EVAL/(ADD)/SHIFT pass.

Decomposition:
- booth_pkg: ctl_code_t (Load/Reset/Shift/Hold), M codes LD/HD, adder ops Add/Sub, state_t enum {IDLE, LOAD, EVAL, ADD, SHIFT, DONE}.
- Optional sub-module booth_iter_counter: load value, decrement enable, last flag (iter==1).
- Output decode stays in booth_sequencer.

Test Plan:
- reset=1 for 2 edges, then low with start=0 -> all outputs at reset values; state IDLE for 5 cycles.
- WIDTH=4, start=1, Q_in=00 throughout -> Load/LD/Reset for 1 cycle, then (Hold, Shift) x4, iter 4->0, done_sig=1 at cycle 9. Drop start -> IDLE next edge.
- WIDTH=4, Q_in cycling 01,10,11,00 per EVAL -> ADD with adder_sig=Add, ADD with Sub, no ADD, no ADD; done_sig at cycle 11.
- start held high through DONE for 4 cycles -> done_sig stays 1, no new LOAD. Drop start -> IDLE; re-raise -> fresh LOAD with iter=4.
- abort=1 during second ADD -> IDLE next edge, outputs Hold/HD, done_sig never 1. Repeat with reset=1 instead -> same result, plus op=Add and iter=0.
- abort and start both high in IDLE -> stays IDLE. WIDTH=1 build with Q_in=10 -> LOAD, EVAL, ADD(Sub), SHIFT, DONE at cycle 4.
